// File: rtl/store_merge_unit_pkg.sv
// store_merge_unit_pkg: access-size and FSM encodings shared by the store and load paths.
package store_merge_unit_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_e;
  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] lo);
    return size == SZ_ILL || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
  endfunction
endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: insert a byte/halfword into its little-endian lane of an existing word.
module store_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);
  always_comb begin
    merged = old_word;
    if (size == SZ_BYTE) merged[{addr_lo, 3'b000} +: 8] = data[7:0];
    else if (size == SZ_HALF) merged[{addr_lo[1], 4'b0000} +: 16] = data[15:0];
    else merged = data;
  end
endmodule

// File: rtl/store_merge_unit.sv
// store_merge_unit: sb/sh/sw store engine; sub-word stores read-modify-write the containing word.
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic              mem_rd_valid,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic              done,
  output logic              err
);
  state_e            state_q, state_d;
  logic [1:0]        lo_q, lo_d, size_q, size_d;
  logic [31:0]       data_q, data_d, mem_wr_data_q, mem_wr_data_d, merged;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d, mem_wr_en_q, mem_wr_en_d;
  logic              done_q, done_d, err_q, err_d;

  store_lane_merge u_merge (
    .old_word(mem_rd_data),
    .data    (data_q),
    .size    (size_q),
    .addr_lo (lo_q),
    .merged  (merged)
  );

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    size_d        = size_q;
    data_d        = data_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_rd_en_d   = 1'b0;
    mem_wr_en_d   = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        lo_d   = req_addr[1:0];
        size_d = req_size;
        data_d = req_data;
        if (bad_req(req_size, req_addr[1:0])) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          mem_addr_d    = {req_addr[ADDR_W-1:2], 2'b00};
          state_d       = req_size == SZ_WORD ? WR : RD;
          mem_wr_en_d   = req_size == SZ_WORD;
          mem_rd_en_d   = req_size != SZ_WORD;
          mem_wr_data_d = req_data;
        end
      end
      RD:   state_d = WAIT;
      WAIT: if (mem_rd_valid) begin
        state_d       = WR;
        mem_wr_en_d   = 1'b1;
        mem_wr_data_d = merged;
      end
      WR: begin
        state_d    = RESP;
        done_d     = 1'b1;
        mem_addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lo_q          <= '0;
      size_q        <= '0;
      data_q        <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      size_q        <= size_d;
      data_q        <= data_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign req_ready   = state_q == IDLE;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = mem_wr_data_q;
  assign done        = done_q;
  assign err         = err_q;
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed stores with a timed event scoreboard checked by a negedge monitor.
module tb_store_merge_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0, req_data = '0, mem_addr, mem_rd_data = '0, mem_wr_data;
  logic [1:0]  req_size = '0;
  logic        mem_rd_en, mem_rd_valid = 1'b0, mem_wr_en, done, err;
  int          checks = 0, errors = 0, cyc = 0;

  typedef struct {int k; int cy; logic [31:0] a; logic [31:0] d;} ev_t;
  ev_t q[$];

  store_merge_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_data(req_data),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", n, g, e, cyc);
    end
  endtask

  // kinds: 0 read, 1 write, 2 done, 3 err
  task automatic expect_ev(input int k);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind %0d at cycle %0d addr %h data %h", k, cyc, mem_addr, mem_wr_data);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.cy != cyc || (k < 2 && e.a !== mem_addr) || (k == 1 && e.d !== mem_wr_data)) begin
        errors++;
        $display("FAIL event got kind %0d cyc %0d addr %h data %h exp kind %0d cyc %0d addr %h data %h",
                 k, cyc, mem_addr, mem_wr_data, e.k, e.cy, e.a, e.d);
      end
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("rd_wr_excl", 32'(mem_rd_en & mem_wr_en), 32'd0);
    chk("done_err_excl", 32'(done & err), 32'd0);
    if (req_ready) chk("idle_addr", mem_addr, 32'd0);
    if (mem_rd_en) expect_ev(0);
    if (mem_wr_en) expect_ev(1);
    if (done) expect_ev(2);
    if (err) expect_ev(3);
  end

  task automatic push(input int k, input int cy, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.k = k; e.cy = cy; e.a = a; e.d = d;
    q.push_back(e);
  endtask

  // kind: 0 word store, 1 sub-word store, 2 rejected; exp_wd is the hand-computed written word
  task automatic issue(input int kind, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                       input int dly, input logic [31:0] rw, input logic [31:0] exp_wd,
                       input bit hold, output int c);
    int n;
    logic [31:0] wa;
    req_valid = 1'b1; req_addr = a; req_size = s; req_data = d;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    c = cyc;
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout addr %h", a);
      req_valid = 1'b0;
      return;
    end
    wa = {a[31:2], 2'b00};
    if (kind == 2) push(3, c + 1, 0, 0);
    else if (kind == 0) begin
      push(1, c + 1, wa, exp_wd);
      push(2, c + 2, 0, 0);
    end else begin
      push(0, c + 1, wa, 0);
      push(1, c + 2 + dly, wa, exp_wd);
      push(2, c + 3 + dly, 0, 0);
    end
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    if (kind == 1) begin
      repeat (dly) begin @(posedge clk); #1; end
      mem_rd_valid = 1'b1; mem_rd_data = rw;
      @(posedge clk); #1;
      mem_rd_valid = 1'b0;
    end else if (kind == 2) begin
      @(posedge clk); #1;
      chk("ready_after_err", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic chk_quiet(input string n);
    chk({n, "_ready"}, 32'(req_ready), 32'd1);
    chk({n, "_addr"}, mem_addr, 32'd0);
    chk({n, "_strobes"}, {28'd0, mem_rd_en, mem_wr_en, done, err}, 32'd0);
    chk({n, "_wdata"}, mem_wr_data, 32'd0);
  endtask

  initial begin
    int c, c1, c2, c3, n;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 32'h100, 2'b10, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, c);
    issue(1, 32'h103, 2'b00, 32'h123456AB, 1, 32'h11223344, 32'hAB223344, 0, c);
    issue(1, 32'h202, 2'b01, 32'hFFFF8001, 4, 32'hAAAABBBB, 32'h8001BBBB, 0, c);
    issue(1, 32'h101, 2'b00, 32'h000000FF, 2, 32'h00000000, 32'h0000FF00, 0, c);
    issue(1, 32'h100, 2'b00, 32'hFFFFFF5A, 1, 32'h01020304, 32'h0102035A, 0, c);
    issue(1, 32'h102, 2'b00, 32'h00000077, 3, 32'h00000000, 32'h00770000, 0, c);
    issue(1, 32'h200, 2'b01, 32'h00001234, 1, 32'hFFFFFFFF, 32'hFFFF1234, 0, c);
    issue(2, 32'h201, 2'b01, 32'h0, 0, 0, 0, 0, c);
    issue(2, 32'h302, 2'b10, 32'h0, 0, 0, 0, 0, c);
    issue(2, 32'h100, 2'b11, 32'h0, 0, 0, 0, 0, c);
    issue(0, 32'h400, 2'b10, 32'h11111111, 0, 0, 32'h11111111, 1, c1);
    issue(0, 32'h404, 2'b10, 32'h22222222, 0, 0, 32'h22222222, 1, c2);
    issue(0, 32'h408, 2'b10, 32'h33333333, 0, 0, 32'h33333333, 0, c3);
    chk("b2b_spacing1", 32'(c2 - c1), 32'd3);
    chk("b2b_spacing2", 32'(c3 - c2), 32'd3);
    repeat (4) @(posedge clk);
    #1;
    // reset in WAIT: only the read may ever appear
    req_valid = 1'b1; req_addr = 32'h500; req_size = 2'b00; req_data = 32'hCC;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    push(0, cyc + 1, 32'h500, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    @(posedge clk); #1;
    chk_quiet("midrst2");
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_rd_valid = 1'b1; mem_rd_data = 32'h99999999;
    @(posedge clk); #1;
    mem_rd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk_quiet("post_orphan");
    n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of req_addr and mem_addr.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  store request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_addr  input  ADDR_W  byte address of the store.
REQ-007 req_size  input  2  00 byte (sb), 01 halfword (sh), 10 word (sw), 11 illegal.
REQ-008 req_data  input  32  register value; only the low 8/16/32 bits are stored, per size.
REQ-009 mem_addr  output  ADDR_W  word-aligned address (req_addr with [1:0] forced to 00).
REQ-010 mem_rd_en  output  1  one-cycle read strobe to word memory.
REQ-011 mem_rd_valid  input  1  mem_rd_data valid; arrives one or more cycles after mem_rd_en.
REQ-012 mem_rd_data  input  32  read word.
REQ-013 mem_wr_en  output  1  one-cycle write strobe.
REQ-014 mem_wr_data  output  32  full word to write.
REQ-015 done  output  1  one-cycle pulse when a store completes.
REQ-016 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-017 The FSM SHALL have the states IDLE, RD, WAIT, WR and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; the address, size and data SHALL be registered on acceptance.
REQ-019 The request SHALL be rejected when size=11, when size=01 with addr[0]=1, or when size=10 with addr[1:0]!=00.
REQ-020 On rejection: RESP state, err=1 for exactly one cycle, then IDLE; no mem_rd_en or mem_wr_en asserted.
REQ-021 Word store: the FSM SHALL go IDLE->WR, assert mem_wr_en with mem_wr_data=req_data for one cycle, then go RESP (done=1 for one cycle), then IDLE; latency from acceptance to done = 2 cycles.
REQ-022 Sub-word store: IDLE->RD, asserting mem_rd_en for one cycle; then WAIT until mem_rd_valid=1.
REQ-023 In WAIT, on mem_rd_valid, the unit SHALL register the merged word and go to WR.
REQ-024 After WR, the unit SHALL go to RESP (done=1), then IDLE; latency = 3 cycles + memory read delay.
REQ-025 Lanes are little-endian: byte lane = addr[1:0] (lane 0 = bits 7:0); halfword lane = addr[1] (0 = bits 15:0, 1 = bits 31:16).
REQ-026 Merge: the target lane SHALL take req_data[7:0] or req_data[15:0]; all other bits SHALL come unchanged from mem_rd_data; req_data upper bits SHALL be ignored (truncation, no overflow check).
REQ-027 mem_addr SHALL hold the registered word address from RD through WR and SHALL be 0 in IDLE.
REQ-028 mem_rd_valid outside WAIT SHALL be ignored.
REQ-029 done and err SHALL never be asserted in the same cycle; mem_rd_en and mem_wr_en SHALL never both be 1.
REQ-030 A new request SHALL be accepted the cycle after RESP (back-to-back throughput of one store per 3 cycles for words).

Reset
REQ-031 While Rst=0: state=IDLE and req_ready=1; mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, done and err = 0; the internal registers are cleared.
REQ-032 Reset asserted mid-operation (any state) SHALL abandon the store with no write issued; a read already issued is orphaned and its mem_rd_valid is ignored.

Structure
REQ-033 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings SHALL live in the shared package, common with the load/sign-extension path.
REQ-034 The lane merge SHALL be one combinational sub-module, store_lane_merge (inputs: old word, data, size, addr[1:0]; output: merged word).

Verification
REQ-035 sw addr=0x100, data=0xDEADBEEF -> one mem_wr_en, mem_addr=0x100, wr_data=0xDEADBEEF, done 2 cycles after accept, no mem_rd_en.
REQ-036 sb addr=0x103, data=0x123456AB, rd_data=0x11223344 -> wr_data=0xAB223344, mem_addr=0x100.
REQ-037 sh addr=0x202, data=0xFFFF8001, rd_data=0xAAAABBBB, rd_valid 4 cycles late -> wr_data=0x8001BBBB, done after write.
REQ-038 sh addr=0x201, then sw addr=0x302, then size=11 -> err pulse each, no memory strobes, req_ready back to 1 the cycle after.
REQ-039 sb accepted, Rst=0 asserted in WAIT, rd_valid delivered after Rst is released -> no mem_wr_en, no done, all outputs 0 during reset.
REQ-040 Three back-to-back sw with req_valid held high -> exactly 3 writes, 3 done pulses, a spacing of 3 cycles, in order.
